imem_responder: RTL and testbench

//   Instruction-memory responder for the core's fetch port: receives the fetch address, returns the

---
 rtl/imem_responder.sv | 171 +++++++++++++++++
 tb/tb_imem_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//   Instruction-memory responder for the core fetch port. It samples the fetch
//   byte address, waits a configurable number of cycles, and then returns the
//   instruction word from a host-preloaded word array. Faulting fetches
//   (misaligned, below the base address, or beyond the array) return a NOP and
//   raise fetch_err.
//
// Ports
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset
//   inst_addr    fetch byte address from the core (combinational pc_next)
//   instruction  registered instruction word for the held address
//   inst_ready   registered, 1 = instruction valid for the held address
//   load_en      host write strobe into the array (highest priority)
//   load_addr    host word index
//   load_data    host write data
//   fetch_err    registered, 1 = current response is a faulting fetch
//   err_count    saturating count of faulting responses
// ---------------------------------------------------------------------------
module imem_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013,
  localparam int         ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_addr,
  output logic [31:0]       instruction,
  output logic              inst_ready,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              fetch_err,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
  // Counter reload value; the WAIT path is never taken when WAIT_STATES is 0.
  localparam logic [3:0]  WAIT_M1 = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [31:0]       mem_r [DEPTH_WORDS];

  state_t            state_r;
  state_t            state_nxt_s;
  logic [31:0]       addr_q_r;
  logic [31:0]       addr_nxt_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_nxt_s;
  logic              ready_nxt_s;
  logic              err_nxt_s;
  logic              new_addr_s;
  logic              resp_s;
  logic [31:0]       resp_addr_s;
  logic [31:0]       resp_off_s;
  logic              resp_fault_s;
  logic [ADDR_W-1:0] rd_idx_s;

  // Misaligned, below base, or past the last word.
  function automatic logic is_fault(input logic [31:0] addr);
    logic [31:0] off;
    off      = addr - BASE_ADDR;
    is_fault = (addr[1:0] != 2'b00) || (addr < BASE_ADDR) || ((off >> 2) >= DEPTH_L);
  endfunction

  // Next-state, response selection and output next values.
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_q_r;
    cnt_nxt_s   = cnt_r;
    ready_nxt_s = inst_ready;
    err_nxt_s   = fetch_err;
    resp_s      = 1'b0;
    resp_addr_s = addr_q_r;
    // After a load the current address must be refetched so a write to it is seen.
    new_addr_s  = (state_r == ST_IDLE) || (state_r == ST_LOAD) || (inst_addr != addr_q_r);

    if (load_en) begin
      state_nxt_s = ST_LOAD;
      ready_nxt_s = 1'b0;
      err_nxt_s   = 1'b0;
    end else if (new_addr_s) begin
      addr_nxt_s = inst_addr;
      if (WAIT_STATES == 0) begin
        resp_s      = 1'b1;
        resp_addr_s = inst_addr;
        state_nxt_s = ST_VALID;
      end else begin
        // A redirect while waiting also lands here and restarts the full wait.
        cnt_nxt_s   = WAIT_M1;
        ready_nxt_s = 1'b0;
        err_nxt_s   = 1'b0;
        state_nxt_s = ST_WAIT;
      end
    end else begin
      case (state_r)
        ST_WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_nxt_s = cnt_r - 4'd1;
          end else begin
            resp_s      = 1'b1;
            state_nxt_s = ST_VALID;
          end
        end
        ST_VALID: begin
          state_nxt_s = ST_VALID;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end

    resp_off_s   = resp_addr_s - BASE_ADDR;
    rd_idx_s     = ADDR_W'(resp_off_s >> 2);
    resp_fault_s = is_fault(resp_addr_s);
    if (resp_s) begin
      ready_nxt_s = 1'b1;
      err_nxt_s   = resp_fault_s;
    end else begin
      ready_nxt_s = ready_nxt_s;
    end
  end

  // Host write port; array contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_r[load_addr] <= load_data;
    end
  end

  // State register, held address, wait counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      addr_q_r    <= 32'h0000_0000;
      cnt_r       <= 4'd0;
      instruction <= NOP_WORD;
      inst_ready  <= 1'b0;
      fetch_err   <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      addr_q_r   <= addr_nxt_s;
      cnt_r      <= cnt_nxt_s;
      inst_ready <= ready_nxt_s;
      fetch_err  <= err_nxt_s;
      if (resp_s) begin
        if (resp_fault_s) begin
          instruction <= NOP_WORD;
          // Counted once per response edge, never per held cycle.
          if (err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
          end
        end else begin
          instruction <= mem_r[rd_idx_s];
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic        load_en;
  logic [11:0] load_addr;
  logic [31:0] load_data;

  logic [31:0] instr0, instr2, instr3;
  logic        rdy0, rdy2, rdy3;
  logic        ferr0, ferr2, ferr3;
  logic [7:0]  ecnt0, ecnt2, ecnt3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .instruction(instr0), .inst_ready(rdy0),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .fetch_err(ferr0), .err_count(ecnt0));

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .instruction(instr2), .inst_ready(rdy2),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .fetch_err(ferr2), .err_count(ecnt2));

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .instruction(instr3), .inst_ready(rdy3),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .fetch_err(ferr3), .err_count(ecnt3));

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [11:0] idx, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = idx;
    load_data = data;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (instr0 !== 32'h0000_0013 || rdy0 !== 1'b0 || ferr0 !== 1'b0 || ecnt0 !== 8'd0) begin
      n_bad++;
      $display("FAIL reset: instr=%h rdy=%b err=%b cnt=%0d, want 00000013 0 0 0", instr0, rdy0, ferr0, ecnt0);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential_fetch();
    logic [31:0] words [4];
    words[0] = 32'hA0A0_0000;
    words[1] = 32'hA1A1_1111;
    words[2] = 32'hA2A2_2222;
    words[3] = 32'hA3A3_3333;
    for (int i = 0; i < 4; i++) begin
      load_word(12'(i), words[i]);
      n_cmp++;
      if (rdy0 !== 1'b0) begin
        n_bad++;
        $display("FAIL load_ready: inst_ready=%b during load, want 0", rdy0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      inst_addr = 32'(4 * i);
      tick();
      n_cmp++;
      if (instr0 !== words[i] || rdy0 !== 1'b1 || ferr0 !== 1'b0) begin
        n_bad++;
        $display("FAIL seq_fetch[%0d]: instr=%h rdy=%b err=%b, want %h 1 0", i, instr0, rdy0, ferr0, words[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    load_word(12'd4, 32'h4444_4444);
    load_word(12'd8, 32'h8888_8888);
    load_word(12'd16, 32'h1616_1616);
    inst_addr = 32'h0000_0010;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (rdy2 !== 1'b0) begin
        n_bad++;
        $display("FAIL wait2_low[%0d]: inst_ready=%b, want 0", i, rdy2);
      end
    end
    tick();
    n_cmp++;
    if (rdy2 !== 1'b1 || instr2 !== 32'h4444_4444) begin
      n_bad++;
      $display("FAIL wait2_data: rdy=%b instr=%h, want 1 44444444", rdy2, instr2);
    end
  endtask

  task automatic test_redirect();
    inst_addr = 32'h0000_0020;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if (rdy3 !== 1'b1 || instr3 !== 32'h8888_8888) begin
      n_bad++;
      $display("FAIL wait3_settle: rdy=%b instr=%h, want 1 88888888", rdy3, instr3);
    end
    inst_addr = 32'h0000_0010;
    tick();
    inst_addr = 32'h0000_0040;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rdy3 !== 1'b0 || instr3 === 32'h4444_4444) begin
        n_bad++;
        $display("FAIL redirect_low[%0d]: rdy=%b instr=%h, want 0 and not 44444444", i, rdy3, instr3);
      end
      tick();
    end
    n_cmp++;
    if (rdy3 !== 1'b1 || instr3 !== 32'h1616_1616) begin
      n_bad++;
      $display("FAIL redirect_data: rdy=%b instr=%h, want 1 16161616", rdy3, instr3);
    end
  endtask

  task automatic test_faults();
    inst_addr = 32'(4 * DEPTH);
    tick();
    n_cmp++;
    if (instr0 !== 32'h0000_0013 || ferr0 !== 1'b1 || rdy0 !== 1'b1 || ecnt0 !== 8'd1) begin
      n_bad++;
      $display("FAIL fault_range: instr=%h err=%b rdy=%b cnt=%0d, want 00000013 1 1 1", instr0, ferr0, rdy0, ecnt0);
    end
    inst_addr = 32'h0000_0002;
    tick();
    n_cmp++;
    if (instr0 !== 32'h0000_0013 || ferr0 !== 1'b1 || ecnt0 !== 8'd2) begin
      n_bad++;
      $display("FAIL fault_align: instr=%h err=%b cnt=%0d, want 00000013 1 2", instr0, ferr0, ecnt0);
    end
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (ecnt0 !== 8'd2 || ferr0 !== 1'b1) begin
      n_bad++;
      $display("FAIL fault_hold: cnt=%0d err=%b, want 2 1", ecnt0, ferr0);
    end
    for (int i = 0; i < 256; i++) begin
      inst_addr = 32'(4 * DEPTH + 4 * i);
      tick();
    end
    n_cmp++;
    if (ecnt0 !== 8'd255) begin
      n_bad++;
      $display("FAIL fault_saturate: cnt=%0d, want 255", ecnt0);
    end
    inst_addr = 32'h0000_0000;
    tick();
    n_cmp++;
    if (ferr0 !== 1'b0 || instr0 !== 32'hA0A0_0000 || ecnt0 !== 8'd255) begin
      n_bad++;
      $display("FAIL fault_clear: err=%b instr=%h cnt=%0d, want 0 a0a00000 255", ferr0, instr0, ecnt0);
    end
  endtask

  task automatic test_load_in_valid();
    inst_addr = 32'h0000_0008;
    tick();
    n_cmp++;
    if (instr0 !== 32'hA2A2_2222 || rdy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL valid_at_8: instr=%h rdy=%b, want a2a22222 1", instr0, rdy0);
    end
    load_word(12'd2, 32'hDEAD_BEEF);
    n_cmp++;
    if (rdy0 !== 1'b0 || ferr0 !== 1'b0) begin
      n_bad++;
      $display("FAIL load_drop: rdy=%b err=%b, want 0 0", rdy0, ferr0);
    end
    tick();
    n_cmp++;
    if (instr0 !== 32'hDEAD_BEEF || rdy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL load_refetch: instr=%h rdy=%b, want deadbeef 1", instr0, rdy0);
    end
  endtask

  task automatic test_reset_mid_wait();
    inst_addr = 32'h0000_0010;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (rdy3 !== 1'b0 || instr3 !== 32'h0000_0013 || ecnt3 !== 8'd0 || ecnt0 !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_mid_wait: rdy=%b instr=%h cnt3=%0d cnt0=%0d, want 0 00000013 0 0", rdy3, instr3, ecnt3, ecnt0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (rdy3 !== 1'b0 || instr0 !== 32'h4444_4444 || rdy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_wait: rdy3=%b instr0=%h rdy0=%b, want 0 44444444 1", rdy3, instr0, rdy0);
    end
    tick();
    n_cmp++;
    if (rdy3 !== 1'b1 || instr3 !== 32'h4444_4444) begin
      n_bad++;
      $display("FAIL post_reset_data: rdy=%b instr=%h, want 1 44444444", rdy3, instr3);
    end
  endtask

  initial begin
    rst       = 1'b1;
    inst_addr = 32'h0000_0000;
    load_en   = 1'b0;
    load_addr = 12'd0;
    load_data = 32'h0000_0000;
    test_reset();
    test_sequential_fetch();
    test_wait_states();
    test_redirect();
    test_faults();
    test_load_in_valid();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
